blit_cmd_arbiter: RTL and testbench

//  Shares the blitter command-word port (hwregs_blit_valid/command/privaledge) between
//  N_REQ requesters, e.g. CPU user regs, kernel regs, command DMA. Multi-word commands are

---
 rtl/blit_cmd_arbiter_pkg.sv | 25 ++
 rtl/blit_cmd_arbiter_rr_pick.sv | 27 ++
 rtl/blit_cmd_arbiter.sv | 112 +++++++++++
 tb/tb_blit_cmd_arbiter.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/blit_cmd_arbiter_pkg.sv
// Shared blitter definitions: command opcodes, command word type and
// the arbiter state encoding used by the command-port arbiter.
package blit_cmd_arbiter_pkg;

    localparam logic [7:0] BLIT_CMD_NOP       = 8'h00;
    localparam logic [7:0] BLIT_CMD_DRAW_RECT = 8'h01;
    localparam logic [7:0] BLIT_CMD_COPY_RECT = 8'h02;
    localparam logic [7:0] BLIT_CMD_DRAW_TEXT = 8'h03;
    localparam logic [7:0] BLIT_CMD_SETUP     = 8'h04;

    // {priv, data}
    typedef logic [32:0] blit_word_t;

    typedef enum logic {
        ST_IDLE,
        ST_LOCKED
    } arb_state_t;

    function automatic logic [1:0] rr_next(input logic [1:0] idx, input int n);
        if (int'(idx) + 1 >= n)
            return 2'd0;
        return idx + 2'd1;
    endfunction

endpackage

// File: rtl/blit_cmd_arbiter_rr_pick.sv
// Rotating-priority search: first valid port starting at i_rr, wrapping
// modulo N.
module blit_cmd_arbiter_rr_pick #(
    parameter int N = 2
) (
    input  logic [1:0]   i_rr,
    input  logic [N-1:0] i_valid,
    output logic [1:0]   o_grant,
    output logic         o_any
);
    int w_idx;

    // Walk from the farthest candidate back to i_rr so the nearest wins.
    always_comb begin
        o_grant = i_rr;
        o_any   = |i_valid;
        w_idx   = 0;
        for (int k = N - 1; k >= 0; k--) begin
            w_idx = int'(i_rr) + k;
            if (w_idx >= N)
                w_idx = w_idx - N;
            if (i_valid[w_idx])
                o_grant = 2'(w_idx);
        end
    end

endmodule

// File: rtl/blit_cmd_arbiter.sv
// Round-robin arbiter for the blitter command-word port; multi-word
// packets hold the port until their last word, issue gated on FIFO room.
module blit_cmd_arbiter
    import blit_cmd_arbiter_pkg::*;
#(
    parameter int         N_REQ       = 2,
    parameter logic [3:0] PRIV_MASK   = 4'b0010,
    parameter int         SLOT_MARGIN = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [N_REQ*32-1:0]   req_data,
    input  logic [N_REQ-1:0]      req_last,
    input  logic [N_REQ-1:0]      req_priv,
    output logic [N_REQ-1:0]      req_ready,
    output logic                  blit_valid,
    output logic [31:0]           blit_command,
    output logic                  blit_privaledge,
    input  logic [9:0]            fifo_slots_free,
    output logic [1:0]            owner,
    output logic                  locked,
    output logic [31:0]           words_issued
);
    arb_state_t r_state;
    arb_state_t w_state_nxt;
    logic [1:0]  r_rr;
    logic [1:0]  r_owner;
    logic        r_bv;
    logic [31:0] r_cmd;
    logic        r_priv;
    logic [31:0] r_words;
    logic [1:0]  w_pick;
    logic        w_any;
    logic [1:0]  w_gnt;
    logic        w_gv;
    logic        w_last;
    logic        w_can_issue;
    logic        w_xfer;
    blit_word_t  w_word;

    blit_cmd_arbiter_rr_pick #(.N(N_REQ)) u_pick (
        .i_rr    (r_rr),
        .i_valid (req_valid),
        .o_grant (w_pick),
        .o_any   (w_any)
    );

    assign w_can_issue = fifo_slots_free > 10'(SLOT_MARGIN);
    assign w_gnt       = (r_state == ST_LOCKED) ? r_owner : w_pick;
    // In IDLE w_gv equals w_any since the picked port is valid when any is.
    assign w_xfer      = !reset && w_can_issue && w_gv;

    always_comb begin
        w_word = '0;
        w_last = 1'b0;
        w_gv   = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_gnt == 2'(i)) begin
                w_word = {req_priv[i] & PRIV_MASK[i], req_data[32*i +: 32]};
                w_last = req_last[i];
                w_gv   = req_valid[i];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < N_REQ; i++)
            req_ready[i] = w_xfer && (w_gnt == 2'(i));
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:   if (w_xfer && !w_last) w_state_nxt = ST_LOCKED;
            ST_LOCKED: if (w_xfer && w_last)  w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_rr    <= 2'd0;
            r_owner <= 2'd0;
            r_bv    <= 1'b0;
            r_cmd   <= 32'd0;
            r_priv  <= 1'b0;
            r_words <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_bv    <= w_xfer;
            r_words <= r_words + {31'd0, r_bv};
            if (w_xfer) begin
                r_owner <= w_gnt;
                r_cmd   <= w_word[31:0];
                r_priv  <= w_word[32];
                if (w_last)
                    r_rr <= rr_next(w_gnt, N_REQ);
            end
        end
    end

    assign blit_valid      = r_bv;
    assign blit_command    = r_cmd;
    assign blit_privaledge = r_priv;
    assign owner           = r_owner;
    assign locked          = (r_state == ST_LOCKED);
    assign words_issued    = r_words;

endmodule

// File: tb/tb_blit_cmd_arbiter.sv
// Bench for blit_cmd_arbiter: directed scenarios plus random traffic,
// all checked against a packet-level reference model.
module tb_blit_cmd_arbiter;
    localparam int N = 2;
    localparam logic [1:0] MASK = 2'b10;

    logic          clock = 1'b0;
    logic          reset;
    logic [N-1:0]  req_valid, req_last, req_priv, req_ready;
    logic [63:0]   req_data;
    logic          blit_valid, blit_privaledge, locked;
    logic [31:0]   blit_command, words_issued;
    logic [9:0]    fifo_slots_free;
    logic [1:0]    owner;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int          m_rr, m_own;
    bit          m_lock, m_bv, m_priv;
    logic [31:0] m_cmd, m_words;

    blit_cmd_arbiter u_dut (
        .clock           (clock),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_data        (req_data),
        .req_last        (req_last),
        .req_priv        (req_priv),
        .req_ready       (req_ready),
        .blit_valid      (blit_valid),
        .blit_command    (blit_command),
        .blit_privaledge (blit_privaledge),
        .fifo_slots_free (fifo_slots_free),
        .owner           (owner),
        .locked          (locked),
        .words_issued    (words_issued)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_rr = 0; m_own = 0; m_lock = 0; m_bv = 0;
        m_priv = 0; m_cmd = 0; m_words = 0;
    endtask

    // One cycle: drive at negedge, check settled outputs, advance model.
    task automatic step(input bit rst, input logic [1:0] v, input logic [1:0] l,
                        input logic [1:0] p, input logic [31:0] d0,
                        input logic [31:0] d1, input logic [9:0] s);
        int g;
        logic [1:0] exp_rdy;
        logic [31:0] d [2];
        @(negedge clock);
        reset = rst; req_valid = v; req_last = l; req_priv = p;
        req_data = {d1, d0}; fifo_slots_free = s;
        #1;
        d[0] = d0; d[1] = d1;
        g = -1;
        if (!rst && s > 10'd4) begin
            if (m_lock) begin
                if (v[m_own]) g = m_own;
            end else begin
                for (int k = N - 1; k >= 0; k--)
                    if (v[(m_rr + k) % N]) g = (m_rr + k) % N;
            end
        end
        exp_rdy = (g < 0) ? 2'b00 : 2'(1 << g);
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        chk("blit_valid", 64'(blit_valid), 64'(m_bv));
        chk("blit_command", 64'(blit_command), 64'(m_cmd));
        chk("blit_priv", 64'(blit_privaledge), 64'(m_priv));
        chk("owner", 64'(owner), 64'(m_own));
        chk("locked", 64'(locked), 64'(m_lock));
        chk("words_issued", 64'(words_issued), 64'(m_words));
        if (rst) begin
            model_reset();
        end else begin
            m_words = m_words + 32'(m_bv);
            m_bv = (g >= 0);
            if (g >= 0) begin
                m_own = g;
                m_cmd = d[g];
                m_priv = p[g] & MASK[g];
                if (l[g]) begin
                    m_lock = 0;
                    m_rr = (g + 1) % N;
                end else begin
                    m_lock = 1;
                end
            end
        end
    endtask

    function automatic logic [31:0] op(input logic [7:0] code, input int n);
        return {code, 24'(n)};
    endfunction

    function automatic logic [9:0] rnd_slots();
        unique case ($urandom_range(0, 5))
            0: return 10'd3;
            1: return 10'd4;
            2: return 10'd5;
            3: return 10'(($urandom_range(0, 1023)));
            default: return 10'd500;
        endcase
    endfunction

    initial begin
        reset = 1'b1; req_valid = '0; req_last = '0; req_priv = '0;
        req_data = '0; fifo_slots_free = 10'd500;
        repeat (2) @(posedge clock);
        model_reset();
        step(1, 2'b00, 2'b00, 2'b00, 0, 0, 500);

        // 3-word DRAW_RECT from port 0
        for (int i = 0; i < 3; i++)
            step(0, 2'b01, (i == 2) ? 2'b01 : 2'b00, 2'b00, op(8'h01, i), 0, 500);
        step(0, 2'b00, 2'b00, 2'b00, 0, 0, 500);
        step(0, 2'b00, 2'b00, 2'b00, 0, 0, 500);
        chk("t1_words", 64'(words_issued), 64'd3);

        // Simultaneous single-word requests, two rounds
        for (int i = 0; i < 4; i++)
            step(0, 2'b11, 2'b11, 2'b00, op(8'h02, i), op(8'h03, i), 500);

        // Port 1 8-word privileged SETUP with port 0 contending
        step(0, 2'b10, 2'b00, 2'b10, 0, op(8'h04, 0), 500);
        for (int i = 1; i < 8; i++)
            step(0, 2'b11, (i == 7) ? 2'b11 : 2'b01, 2'b11,
                 op(8'h01, 99), op(8'h04, i), 500);
        step(0, 2'b01, 2'b01, 2'b00, op(8'h01, 100), 0, 500);

        // Port 0 privileged request is masked
        for (int i = 0; i < 2; i++)
            step(0, 2'b01, (i == 1) ? 2'b01 : 2'b00, 2'b01, op(8'h04, i), 0, 500);
        step(0, 2'b00, 2'b00, 2'b00, 0, 0, 500);
        chk("t4_priv", 64'(blit_privaledge), 64'd0);

        // Margin stall mid-packet
        step(0, 2'b01, 2'b00, 2'b00, op(8'h01, 7), 0, 500);
        step(0, 2'b11, 2'b01, 2'b00, op(8'h01, 8), op(8'h02, 8), 4);
        step(0, 2'b11, 2'b00, 2'b00, op(8'h01, 8), op(8'h02, 8), 4);
        chk("t5_locked", 64'(locked), 64'd1);
        step(0, 2'b11, 2'b01, 2'b00, op(8'h01, 9), op(8'h02, 9), 5);

        // Reset while locked
        step(0, 2'b01, 2'b00, 2'b00, op(8'h02, 1), 0, 500);
        step(1, 2'b01, 2'b00, 2'b00, op(8'h02, 2), 0, 500);
        step(0, 2'b00, 2'b00, 2'b00, 0, 0, 500);
        chk("t6_locked", 64'(locked), 64'd0);
        chk("t6_owner", 64'(owner), 64'd0);

        // Random traffic
        for (int c = 0; c < 3000; c++)
            step(($urandom_range(0, 99) == 0), 2'($urandom), 2'($urandom),
                 2'($urandom), $urandom, $urandom, rnd_slots());
        step(0, 2'b00, 2'b00, 2'b00, 0, 0, 500);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
